// File: rtl/add4_acc_if.sv
// ---------------------------------------------------------------------------
// add4_acc_if
//
// Purpose: bundles the operand and result handshakes of the add4_acc
// accumulator stage, together with its batch control and status signals.
//
// Signals:
//   start      batch start request                (master -> slave)
//   in_valid   operand valid                      (master -> slave)
//   in_data    4-bit operand, bit 0 = LSB         (master -> slave)
//   in_ready   operand accepted when high         (slave  -> master)
//   out_valid  batch result valid                 (slave  -> master)
//   out_ready  consumer accepts the result        (master -> slave)
//   acc        running / final 4-bit sum          (slave  -> master)
//   carries    count of adder carry-outs          (slave  -> master)
//   ovf        sticky batch overflow              (slave  -> master)
//   busy       high while a batch is in flight    (slave  -> master)
//
// Modports:
//   master  producer/consumer side (drives start, operands, out_ready)
//   slave   accumulator side (add4_acc)
// ---------------------------------------------------------------------------
interface add4_acc_if #(
    parameter int CW = 4
) ();
    logic          start;
    logic          in_valid;
    logic [3:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    acc;
    logic [CW-1:0] carries;
    logic          ovf;
    logic          busy;

    modport master (
        output start,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc,
        input  carries,
        input  ovf,
        input  busy
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc,
        output carries,
        output ovf,
        output busy
    );
endinterface

// File: rtl/add4_acc.sv
// ---------------------------------------------------------------------------
// add4_acc
//
// Purpose: sequential accumulator placed behind a 4-bit ripple-carry adder.
// A batch of NOPS operands is accepted over a valid/ready handshake; each one
// is added to the running 4-bit total, the sum is registered back as the new
// total and carry-outs are counted. When the batch is complete the result is
// offered to a consumer over a second valid/ready handshake.
//
// Without overflow the true batch sum is carries*16 + acc.
//
// Parameters:
//   NOPS  operands per batch, 1..15
//   CW    width of the carry counter
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   add4_acc_if.slave (start, operand handshake, result handshake,
//         acc / carries / ovf / busy status)
//
// Configuration macro:
//   ADD4_ACC_SAT_EN  when defined, a carry-out clamps acc to 4'hF and sets
//                    ovf instead of counting carries (carries stays 0).
//                    When undefined, acc wraps and carries are counted.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module add4_acc #(
    parameter int NOPS = 4,
    parameter int CW   = 4
) (
    input logic        clk,
    input logic        rst,
    add4_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Value of the op counter when the final operand of a batch is accepted.
    localparam logic [3:0] OPS_LAST = 4'(NOPS - 1);

`ifndef ADD4_ACC_SAT_EN
    localparam logic [CW-1:0] CARRY_MAX = '1;
`endif

    state_t        state_q,     state_d;
    logic [3:0]    acc_q,       acc_d;
    logic [CW-1:0] carries_q,   carries_d;
    logic          ovf_q,       ovf_d;
    logic [3:0]    op_cnt_q,    op_cnt_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q,      busy_d;

    logic [3:0]    add_sum;
    logic          add_cout;
    logic          take_op;

    // The Add4 datapath: a 4-bit ripple-carry adder built from full-adder
    // cells, fed with the running total and the incoming operand. The carry
    // ripples through a block-local variable so there is no combinational
    // vector feeding back on itself.
    always_comb begin
        logic c;
        c       = 1'b0;
        add_sum = 4'h0;
        for (int i = 0; i < 4; i++) begin
            add_sum[i] = acc_q[i] ^ bus.in_data[i] ^ c;
            c          = (acc_q[i] & bus.in_data[i]) | (c & (acc_q[i] ^ bus.in_data[i]));
        end
        add_cout = c;
    end

    // in_ready is registered and only ever high in ACCUM, so it doubles as
    // the "operand may be taken" qualifier.
    assign take_op = bus.in_valid & in_ready_q;

    // Next-state and next-output logic. Every register holds by default; only
    // the transitions below change anything, which is what keeps the result
    // stable in DONE and after returning to IDLE.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carries_d   = carries_q;
        ovf_d       = ovf_q;
        op_cnt_d    = op_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ACCUM;
                    acc_d      = 4'h0;
                    carries_d  = '0;
                    ovf_d      = 1'b0;
                    op_cnt_d   = 4'h0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            ACCUM: begin
                if (take_op) begin
                    acc_d    = add_sum;
                    op_cnt_d = op_cnt_q + 4'd1;
                    if (add_cout) begin
`ifdef ADD4_ACC_SAT_EN
                        // Clamp: F + x still carries for any x != 0, so the
                        // total stays pinned at F for the rest of the batch.
                        acc_d = 4'hF;
                        ovf_d = 1'b1;
`else
                        // A carry arriving while the counter is already full
                        // cannot be represented: hold the count, flag ovf.
                        if (carries_q == CARRY_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            carries_d = carries_q + 1'b1;
                        end
`endif
                    end
                    if (op_cnt_q == OPS_LAST) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset in the
    // middle of a batch simply throws the batch away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 4'h0;
            carries_q   <= '0;
            ovf_q       <= 1'b0;
            op_cnt_q    <= 4'h0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carries_q   <= carries_d;
            ovf_q       <= ovf_d;
            op_cnt_q    <= op_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.carries   = carries_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_add4_acc.sv
// ---------------------------------------------------------------------------
// tb_add4_acc
//
// Self-checking bench for add4_acc. Two instances are used: u_dut with the
// default carry counter (NOPS=4, CW=4) and u_dut1 with a 1-bit carry counter
// (NOPS=4, CW=1) to reach counter saturation quickly.
//
// Inputs change and outputs are sampled on the falling clock edge, so every
// sample sees the state produced by the previous rising edge.
// Expected values follow ADD4_ACC_SAT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_add4_acc;

`ifdef ADD4_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;

    add4_acc_if #(.CW(4)) if0 ();
    add4_acc_if #(.CW(1)) if1 ();

    add4_acc #(.NOPS(4), .CW(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    add4_acc #(.NOPS(4), .CW(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // One table row: inputs applied for one cycle, then the outputs expected
    // after the following rising edge.
    typedef struct {
        logic       rst;
        logic       start;
        logic       in_valid;
        logic [3:0] in_data;
        logic       out_ready;
        logic [3:0] acc;
        logic [3:0] carries;
        logic       ovf;
        logic       in_ready;
        logic       out_valid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic iv,
                                input logic [3:0] d, input logic ordy,
                                input logic [3:0] eacc, input logic [3:0] ecar,
                                input logic eovf, input logic eir,
                                input logic eov, input logic ebusy);
        vec_t v;
        v.rst       = r;
        v.start     = s;
        v.in_valid  = iv;
        v.in_data   = d;
        v.out_ready = ordy;
        v.acc       = eacc;
        v.carries   = ecar;
        v.ovf       = eovf;
        v.in_ready  = eir;
        v.out_valid = eov;
        v.busy      = ebusy;
        return v;
    endfunction

    // Drive one cycle of stimulus on the main instance, count a handshake if
    // one is about to be taken, and advance to the next falling edge.
    task automatic applyStimulus(input logic s, input logic iv,
                                 input logic [3:0] d, input logic ordy);
        if0.start     = s;
        if0.in_valid  = iv;
        if0.in_data   = d;
        if0.out_ready = ordy;
        if (if0.in_valid && if0.in_ready) hs_count++;
        @(negedge clk);
    endtask

    // Same for the CW=1 instance.
    task automatic applyStimulus1(input logic s, input logic iv,
                                  input logic [3:0] d, input logic ordy);
        if1.start     = s;
        if1.in_valid  = iv;
        if1.in_data   = d;
        if1.out_ready = ordy;
        @(negedge clk);
    endtask

    // Single comparison; every call counts as one check.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare every status output of the main instance.
    task automatic checkMain(input string tag, input logic [3:0] eacc,
                             input logic [3:0] ecar, input logic eovf,
                             input logic eir, input logic eov, input logic ebusy);
        checkOutput({tag, ".acc"},       int'(if0.acc),       int'(eacc));
        checkOutput({tag, ".carries"},   int'(if0.carries),   int'(ecar));
        checkOutput({tag, ".ovf"},       int'(if0.ovf),       int'(eovf));
        checkOutput({tag, ".in_ready"},  int'(if0.in_ready),  int'(eir));
        checkOutput({tag, ".out_valid"}, int'(if0.out_valid), int'(eov));
        checkOutput({tag, ".busy"},      int'(if0.busy),      int'(ebusy));
    endtask

    // Main test sequence: reset, table-driven batch, then hand-written
    // sequences for stalls, backpressure, mid-batch reset and counter
    // saturation.
    initial begin
        logic [3:0] last_acc;
        logic [3:0] last_car;
        logic       last_ovf;

        if0.start = 1'b0; if0.in_valid = 1'b0; if0.in_data = 4'h0; if0.out_ready = 1'b0;
        if1.start = 1'b0; if1.in_valid = 1'b0; if1.in_data = 4'h0; if1.out_ready = 1'b0;

        // Batch 3,5,7,1: acc 3,8,F then 0 with one carry (wrap) or F with
        // ovf (saturate). start in DONE, including on the result handshake
        // edge, must be ignored. Then a new batch, and a reset mid-batch.
        last_acc = SAT ? 4'hF : 4'h0;
        last_car = SAT ? 4'h0 : 4'h1;
        last_ovf = SAT ? 1'b1 : 1'b0;
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'h3, 0, 4'h3, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'h5, 0, 4'h8, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'h7, 0, 4'hF, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'h1, 0, last_acc, last_car, last_ovf, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 4'h9, 0, last_acc, last_car, last_ovf, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'h0, 1, last_acc, last_car, last_ovf, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, last_acc, last_car, last_ovf, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'hF, 0, 4'hF, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'hF, 4'h0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 4'h2, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h2, 0, 4'h0, 4'h0, 0, 0, 0, 0));

        // Reset: hold for two rising edges, then all outputs must be zero.
        @(negedge clk);
        @(negedge clk);
        checkMain("reset", 4'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("reset1.acc",     int'(if1.acc),     0);
        checkOutput("reset1.carries", int'(if1.carries), 0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            applyStimulus(vecs[i].start, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            checkMain($sformatf("vec%0d", i), vecs[i].acc, vecs[i].carries,
                      vecs[i].ovf, vecs[i].in_ready, vecs[i].out_valid, vecs[i].busy);
        end
        rst = 1'b0;

        // Stalls: operands 2,2,2,2 with three idle cycles before each one.
        hs_count = 0;
        applyStimulus(1, 0, 4'h0, 0);
        for (int op = 0; op < 4; op++) begin
            for (int s = 0; s < 3; s++) begin
                applyStimulus(0, 0, 4'h2, 0);
                checkOutput($sformatf("stall%0d_%0d.in_ready", op, s), int'(if0.in_ready), 1);
                checkOutput($sformatf("stall%0d_%0d.acc", op, s), int'(if0.acc), 2 * op);
            end
            applyStimulus(0, 1, 4'h2, 0);
        end
        checkMain("stall_end", 4'h8, 4'h0, 0, 0, 1, 1);
        checkOutput("stall.handshakes", hs_count, 4);

        // Backpressure: result held for five cycles while operands keep
        // arriving; nothing may change and no operand may be taken.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 1, 4'hF, 0);
            checkMain($sformatf("bp%0d", c), 4'h8, 4'h0, 0, 0, 1, 1);
        end
        checkOutput("bp.handshakes", hs_count, 4);
        applyStimulus(0, 0, 4'h0, 1);
        checkMain("bp_release", 4'h8, 4'h0, 0, 0, 0, 0);

        // Reset after two of four operands, then a clean batch of four 1s.
        applyStimulus(1, 0, 4'h0, 0);
        applyStimulus(0, 1, 4'h5, 0);
        applyStimulus(0, 1, 4'h6, 0);
        checkMain("pre_rst", 4'hB, 4'h0, 0, 1, 0, 1);
        rst = 1'b1;
        applyStimulus(0, 1, 4'h7, 0);
        rst = 1'b0;
        checkMain("mid_rst", 4'h0, 4'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 4'h0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 4'h1, 0);
        checkMain("after_rst", 4'h4, 4'h0, 0, 0, 1, 1);
        applyStimulus(0, 0, 4'h0, 1);
        checkMain("after_rst_done", 4'h4, 4'h0, 0, 0, 0, 0);

        // CW=1 counter saturation: F,F,F,F gives acc C, one counted carry and
        // ovf in wrap mode; in saturate mode acc is pinned at F.
        applyStimulus1(1, 0, 4'h0, 0);
        applyStimulus1(0, 1, 4'hF, 0);
        checkOutput("cw1_op1.acc", int'(if1.acc), 15);
        applyStimulus1(0, 1, 4'hF, 0);
        checkOutput("cw1_op2.acc",     int'(if1.acc),     SAT ? 15 : 14);
        checkOutput("cw1_op2.carries", int'(if1.carries), SAT ? 0 : 1);
        applyStimulus1(0, 1, 4'hF, 0);
        applyStimulus1(0, 1, 4'hF, 0);
        checkOutput("cw1_end.acc",       int'(if1.acc),       SAT ? 15 : 12);
        checkOutput("cw1_end.carries",   int'(if1.carries),   SAT ? 0 : 1);
        checkOutput("cw1_end.ovf",       int'(if1.ovf),       1);
        checkOutput("cw1_end.out_valid", int'(if1.out_valid), 1);
        checkOutput("cw1_end.in_ready",  int'(if1.in_ready),  0);
        applyStimulus1(0, 0, 4'h0, 1);
        checkOutput("cw1_idle.out_valid", int'(if1.out_valid), 0);
        checkOutput("cw1_idle.ovf",       int'(if1.ovf),       1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
